// File: rtl/jtag_id_user_register_if.sv
// TAP-side bundle for the identification/USERCODE data register: DR-state
// qualifiers, instruction selects and serial data in, plus the register's observable outputs.
interface jtag_id_user_register_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 2)
);
  logic             tdi;
  logic             captureDR;
  logic             shiftDR;
  logic             updateDR;
  logic             select_id;
  logic             select_user;
  logic             user_wr;
  logic             tdo;
  logic [WIDTH-1:0] usercode;
  logic [CNTW-1:0]  shift_count;
  logic             length_err;

  modport master (
    output tdi, captureDR, shiftDR, updateDR, select_id, select_user, user_wr,
    input  tdo, usercode, shift_count, length_err
  );

  modport slave (
    input  tdi, captureDR, shiftDR, updateDR, select_id, select_user, user_wr,
    output tdo, usercode, shift_count, length_err
  );
endinterface

// File: rtl/jtag_id_user_register.sv
// JTAG IDCODE/USERCODE data register, shifted LSB-first on tck.
// Define USERCODE_EN to enable USERCODE programming with shift-length checking.
module jtag_id_user_register #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] DEVICE_ID    = WIDTH'(32'h1234_5679),
  parameter logic [WIDTH-1:0] USERCODE_RST = WIDTH'(32'h0000_0001),
  parameter int               CNTW         = $clog2(WIDTH + 2)
) (
  input  logic                     tck,
  input  logic                     trst,
  jtag_id_user_register_if.slave   bus
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  if (WIDTH < 2 || DEVICE_ID[0] != 1'b1) begin : g_param_check
    $error("jtag_id_user_register: WIDTH must be >= 2 and DEVICE_ID[0] must be 1");
  end

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] capture_word;
  logic [CNTW-1:0]  shift_count;
  logic             active;
  logic             capture_en;
  logic             shift_en;

  assign active     = bus.select_id | bus.select_user;
  assign capture_en = bus.captureDR & active;
  assign shift_en   = bus.shiftDR & active & ~bus.captureDR;

`ifdef USERCODE_EN
  logic [WIDTH-1:0] usercode_q;
  logic             length_err_q;
  logic             update_en;

  // Update only acts when no higher-priority qualifier is also asserted.
  assign update_en = bus.updateDR & bus.select_user & bus.user_wr & ~bus.select_id
                   & ~bus.captureDR & ~bus.shiftDR;
  assign capture_word = bus.select_id ? DEVICE_ID : usercode_q;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      usercode_q   <= USERCODE_RST;
      length_err_q <= 1'b0;
    end else if (capture_en) begin
      length_err_q <= 1'b0;
    end else if (update_en) begin
      if (shift_count == CNTW'(WIDTH)) usercode_q <= shift_reg;
      else                             length_err_q <= 1'b1;
    end
  end

  assign bus.usercode   = usercode_q;
  assign bus.length_err = length_err_q;
`else
  logic unused_update_inputs;

  assign unused_update_inputs = bus.updateDR ^ bus.user_wr;
  assign capture_word         = bus.select_id ? DEVICE_ID : USERCODE_RST;
  assign bus.usercode         = USERCODE_RST;
  assign bus.length_err       = 1'b0;
`endif

  // Count saturates so an over-long shift can never alias back to WIDTH.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      shift_reg   <= DEVICE_ID;
      shift_count <= '0;
    end else if (capture_en) begin
      shift_reg   <= capture_word;
      shift_count <= '0;
    end else if (shift_en) begin
      shift_reg <= {bus.tdi, shift_reg[WIDTH-1:1]};
      if (shift_count != CNT_MAX) shift_count <= shift_count + 1'b1;
    end
  end

  assign bus.tdo         = shift_reg[0];
  assign bus.shift_count = shift_count;

  a_idcode_lsb : assert property (@(posedge tck) disable iff (!trst)
    (bus.captureDR && bus.select_id) |=> shift_reg[0]);

endmodule

// File: tb/tb_jtag_id_user_register.sv
// Scoreboard bench for jtag_id_user_register: expected words are queued at
// capture time and compared against the tdo stream as it is shifted out.
module tb_jtag_id_user_register;

  localparam logic [31:0] DEV_ID = 32'h1234_5679;
  localparam logic [31:0] UC_RST = 32'h0000_0001;
`ifdef USERCODE_EN
  localparam bit UC_EN = 1'b1;
`else
  localparam bit UC_EN = 1'b0;
`endif

  logic tck = 1'b0;
  logic trst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_usercode = UC_RST;

  jtag_id_user_register_if #(.WIDTH(32)) bus_if ();

  jtag_id_user_register #(
    .WIDTH(32), .DEVICE_ID(DEV_ID), .USERCODE_RST(UC_RST)
  ) dut (
    .tck(tck), .trst(trst), .bus(bus_if)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic set_sel(input logic sid, input logic suser, input logic wr);
    bus_if.select_id   = sid;
    bus_if.select_user = suser;
    bus_if.user_wr     = wr;
  endtask

  task automatic capture();
    bus_if.captureDR = 1'b1;
    tick();
    bus_if.captureDR = 1'b0;
  endtask

  task automatic update();
    bus_if.updateDR = 1'b1;
    tick();
    bus_if.updateDR = 1'b0;
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    bus_if.shiftDR = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < 32) dout[i] = bus_if.tdo;
      bus_if.tdi = din[i % 32];
      tick();
    end
    bus_if.shiftDR = 1'b0;
  endtask

  task automatic check_stream(input string name, input logic [31:0] got);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: tdo stream %h, expected %h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    trst = 1'b0;
    #12;
    checks++; if (bus_if.tdo !== 1'b1) begin errors++; $display("FAIL reset_tdo: got %b expected 1", bus_if.tdo); end
    checks++; if (bus_if.usercode !== UC_RST) begin errors++; $display("FAIL reset_usercode: got %h expected %h", bus_if.usercode, UC_RST); end
    tick();
    trst = 1'b1;
    tick();
    checks++; if (bus_if.shift_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus_if.shift_count); end
    checks++; if (bus_if.length_err !== 1'b0) begin errors++; $display("FAIL reset_lerr: got %b expected 0", bus_if.length_err); end
    checks++; if (bus_if.tdo !== 1'b1) begin errors++; $display("FAIL reset_tdo_rel: got %b expected 1", bus_if.tdo); end
  endtask

  task automatic test_idcode();
    logic [31:0] rd;
    set_sel(1'b1, 1'b0, 1'b0);
    capture();
    exp_q.push_back(DEV_ID);
    shift_bits(32, $urandom(), rd);
    check_stream("idcode_read", rd);
    checks++; if (bus_if.shift_count !== 6'd32) begin errors++; $display("FAIL idcode_count: got %0d expected 32", bus_if.shift_count); end
  endtask

  task automatic test_user_program();
    logic [31:0] rd;
    set_sel(1'b0, 1'b1, 1'b1);
    capture();
    exp_q.push_back(exp_usercode);
    shift_bits(32, 32'hCAFE_F00D, rd);
    check_stream("user_prog_read_old", rd);
    update();
    if (UC_EN) exp_usercode = 32'hCAFE_F00D;
    checks++; if (bus_if.usercode !== exp_usercode) begin errors++; $display("FAIL user_prog_value: got %h expected %h", bus_if.usercode, exp_usercode); end
    checks++; if (bus_if.length_err !== 1'b0) begin errors++; $display("FAIL user_prog_lerr: got %b expected 0", bus_if.length_err); end
    capture();
    exp_q.push_back(exp_usercode);
    shift_bits(32, 32'h0, rd);
    check_stream("user_readback", rd);
  endtask

  task automatic test_length_err();
    logic [31:0] rd;
    set_sel(1'b0, 1'b1, 1'b1);
    capture();
    shift_bits(31, 32'hDEAD_BEEF, rd);
    checks++; if (bus_if.shift_count !== 6'd31) begin errors++; $display("FAIL short_count: got %0d expected 31", bus_if.shift_count); end
    update();
    checks++; if (bus_if.usercode !== exp_usercode) begin errors++; $display("FAIL short_value: got %h expected %h", bus_if.usercode, exp_usercode); end
    checks++; if (bus_if.length_err !== UC_EN) begin errors++; $display("FAIL short_lerr: got %b expected %b", bus_if.length_err, UC_EN); end
    capture();
    checks++; if (bus_if.length_err !== 1'b0) begin errors++; $display("FAIL lerr_clear: got %b expected 0", bus_if.length_err); end
    shift_bits(40, 32'h5A5A_A5A5, rd);
    checks++; if (bus_if.shift_count !== 6'd40) begin errors++; $display("FAIL long_count: got %0d expected 40", bus_if.shift_count); end
    update();
    checks++; if (bus_if.usercode !== exp_usercode) begin errors++; $display("FAIL long_value: got %h expected %h", bus_if.usercode, exp_usercode); end
    checks++; if (bus_if.length_err !== UC_EN) begin errors++; $display("FAIL long_lerr: got %b expected %b", bus_if.length_err, UC_EN); end
    capture();
    exp_q.push_back(exp_usercode);
    shift_bits(70, 32'h1357_9BDF, rd);
    check_stream("sat_read", rd);
    checks++; if (bus_if.shift_count !== 6'd63) begin errors++; $display("FAIL sat_count: got %0d expected 63", bus_if.shift_count); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    set_sel(1'b0, 1'b1, 1'b1);
    capture();
    shift_bits(16, 32'h0000_FFFE, rd);
    trst = 1'b0;
    #2;
    exp_usercode = UC_RST;
    checks++; if (bus_if.usercode !== UC_RST) begin errors++; $display("FAIL mid_usercode: got %h expected %h", bus_if.usercode, UC_RST); end
    checks++; if (bus_if.tdo !== 1'b1) begin errors++; $display("FAIL mid_tdo: got %b expected 1", bus_if.tdo); end
    checks++; if (bus_if.shift_count !== 6'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bus_if.shift_count); end
    #2;
    trst = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    logic [31:0] rd;
    // Both selects: IDCODE wins; capture beats simultaneous shift.
    set_sel(1'b1, 1'b1, 1'b1);
    bus_if.shiftDR = 1'b1;
    capture();
    bus_if.shiftDR = 1'b0;
    checks++; if (bus_if.shift_count !== 6'd0) begin errors++; $display("FAIL prio_cap_count: got %0d expected 0", bus_if.shift_count); end
    exp_q.push_back(DEV_ID);
    shift_bits(32, 32'hFFFF_FFFF, rd);
    check_stream("prio_id_read", rd);
    // Update with select_id high must not program.
    update();
    checks++; if (bus_if.usercode !== exp_usercode) begin errors++; $display("FAIL prio_id_update: got %h expected %h", bus_if.usercode, exp_usercode); end
    // Shift beats simultaneous update.
    set_sel(1'b0, 1'b1, 1'b1);
    capture();
    shift_bits(31, 32'h8765_4321, rd);
    bus_if.updateDR = 1'b1;
    shift_bits(1, 32'h0, rd);
    bus_if.updateDR = 1'b0;
    checks++; if (bus_if.shift_count !== 6'd32) begin errors++; $display("FAIL prio_shift_count: got %0d expected 32", bus_if.shift_count); end
    checks++; if (bus_if.usercode !== exp_usercode) begin errors++; $display("FAIL prio_shift_update: got %h expected %h", bus_if.usercode, exp_usercode); end
    // Inactive register holds its count.
    set_sel(1'b0, 1'b0, 1'b0);
    shift_bits(3, 32'h0, rd);
    checks++; if (bus_if.shift_count !== 6'd32) begin errors++; $display("FAIL inactive_hold: got %0d expected 32", bus_if.shift_count); end
    // Update without user_wr does nothing.
    set_sel(1'b0, 1'b1, 1'b0);
    update();
    checks++; if (bus_if.usercode !== exp_usercode) begin errors++; $display("FAIL no_wr_update: got %h expected %h", bus_if.usercode, exp_usercode); end
  endtask

  initial begin
    bus_if.tdi = 1'b0;
    bus_if.captureDR = 1'b0;
    bus_if.shiftDR = 1'b0;
    bus_if.updateDR = 1'b0;
    set_sel(1'b0, 1'b0, 1'b0);
    test_reset();
    test_idcode();
    test_user_program();
    test_length_err();
    test_reset_mid();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_id_user_register.md
# jtag_id_user_register

Parametrised JTAG identification data register that captures a fixed device IDCODE or a field-programmable USERCODE and shifts it out LSB-first, with a shift-length checked USERCODE update path. It sits between the TAP controller/instruction decoder and the TDO mux and supersedes the fixed 32-bit ID register. All state runs on the TAP clock domain.

## Interface
- WIDTH, 32: identification register length in bits; must be ≥ 2.
- DEVICE_ID, 32'h1234_5679: IDCODE value, WIDTH bits; bit 0 must be 1.
- USERCODE_RST, 32'h0000_0001: USERCODE value after reset, WIDTH bits.
- CNTW, $clog2(WIDTH+2): shift-counter width (derived; do not override).

- tck  in  1  TAP clock; all state updates on the rising edge.
- trst  in  1  asynchronous, active-low reset.
- tdi  in  1  serial data in.
- captureDR  in  1  Capture-DR state qualifier.
- shiftDR  in  1  Shift-DR state qualifier.
- updateDR  in  1  Update-DR state qualifier.
- select_id  in  1  IDCODE instruction active.
- select_user  in  1  USERCODE instruction active.
- user_wr  in  1  USERCODE-program instruction active (used with select_user).
- tdo  out  1  serial data out, = shift_reg[0].
- usercode  out  WIDTH  current USERCODE value.
- shift_count  out  CNTW  bits shifted since last capture, saturating.
- length_err  out  1  sticky: last USERCODE update had wrong shift length.

## Operation
- Register is active when select_id | select_user; if both high, select_id wins. Inactive: shift_reg, shift_count, length_err hold.
- Capture (captureDR & active): shift_reg ← DEVICE_ID (select_id) or usercode (select_user); shift_count ← 0; length_err ← 0.
- Shift (shiftDR & active, no capture): shift_reg ← {tdi, shift_reg[WIDTH-1:1]}; shift_count ← shift_count + 1, saturating at 2^CNTW − 1 (never wraps).
- Update (updateDR & select_user & user_wr & !select_id): if shift_count == WIDTH, usercode ← shift_reg; else usercode holds and length_err ← 1. Update with select_id or without user_wr: no effect.
- Simultaneous qualifiers (illegal from a compliant TAP): priority capture > shift > update; only highest acts.
- Elaboration check: $error if DEVICE_ID[0] != 1 or WIDTH < 2.
- Simulation assertion: every capture under select_id leaves shift_reg[0] == 1 on the next cycle.

## Timing
- Reset (trst low, asynchronous): shift_reg ← DEVICE_ID, so tdo = 1; usercode ← USERCODE_RST; shift_count ← 0; length_err ← 0. Release is synchronous to tck in the enclosing design.
- Capture to first valid tdo: 0 cycles after the capture edge; tdo is combinational from shift_reg[0].
- Each shift edge presents the next bit on tdo; bit k of the captured word appears after k shift edges.
- usercode and length_err change on the Update-DR rising edge; visible same cycle after the edge.
- Reset mid-shift discards the partial word; usercode returns to USERCODE_RST.
- TDO falling-edge retiming and output enable are outside this block.

## Configuration
- USERCODE_EN defined: USERCODE capture, programming, shift_count checking and length_err as above.
- USERCODE_EN undefined: usercode tied to USERCODE_RST; select_user captures USERCODE_RST; updates ignored; length_err constant 0; shift_count still counts.

## Test plan
- Reset: trst low then high, no capture → tdo = 1, usercode = 0x0000_0001, shift_count = 0, length_err = 0.
- IDCODE read: select_id, capture, 32 shifts → tdo stream 0x1234_5679 LSB-first; shift_count = 32.
- USERCODE program: select_user + user_wr, capture, shift 0xCAFE_F00D LSB-first (32 bits), update → usercode = 0xCAFE_F00D, length_err = 0; re-capture and shift reads back 0xCAFE_F00D.
- Length error: same as above with 31 shifts, then 40 shifts → usercode unchanged, length_err = 1 each time; next capture clears it; shift_count saturates at 63 on 70 shifts.
- Reset mid-operation: trst low after 16 shifts of a USERCODE program → usercode = 0x0000_0001, tdo = 1, shift_count = 0.
- USERCODE_EN undefined: same program sequence → usercode stays 0x0000_0001, length_err stays 0.
